// File: rtl/poker_stream_shifter.sv
// Poker-mode stream consumer: paces the framebuffer source, forwards each 30-bit word
// to the TLC5957 SIN lines with SCLK enable and WRTGS/LATGS latch timing, then blanks.
module poker_stream_shifter #(
    parameter int DATA_W          = 30,
    parameter int N_BITPLANES     = 10,
    parameter int WORDS_PER_PLANE = 48,
    parameter int BLANKING_CYCLES = 72,
    parameter int WRTGS_LEN       = 1,
    parameter int LATGS_LEN       = 3
) (
    input  logic              clk_33,
    input  logic              rst,
    input  logic              enable,
    input  logic              config_busy,
    input  logic [DATA_W-1:0] data,
    output logic              driver_ready,
    output logic [DATA_W-1:0] sin,
    output logic              sclk_en,
    output logic              lat,
    output logic [3:0]        plane_idx,
    output logic              frame_done
);

    localparam int WORD_W  = $clog2(WORDS_PER_PLANE);
    localparam int BLANK_W = $clog2(BLANKING_CYCLES + 1);

    localparam logic [WORD_W-1:0]  LAST_WORD  = WORD_W'(WORDS_PER_PLANE - 1);
    localparam logic [3:0]         LAST_PLANE = 4'(N_BITPLANES - 1);
    localparam logic [BLANK_W-1:0] LAST_BLANK = BLANK_W'(BLANKING_CYCLES - 1);
    localparam logic [WORD_W-1:0]  WRTGS_FROM = WORD_W'(WORDS_PER_PLANE - WRTGS_LEN);
    localparam logic [WORD_W-1:0]  LATGS_FROM = WORD_W'(WORDS_PER_PLANE - LATGS_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WORD_W-1:0]  word_cnt;
    logic [3:0]         plane_cnt;
    logic [BLANK_W-1:0] blank_cnt;
    logic               last_req;

    logic               vld_p0;
    logic [WORD_W-1:0]  word_p0;
    logic [3:0]         plane_p0;
    logic [WORD_W-1:0]  word_p1;

    // The final plane latches with LATGS (longer LAT), the others with WRTGS.
    function automatic logic lat_for(input logic [WORD_W-1:0] w, input logic [3:0] p);
        if (p == LAST_PLANE)
            return (w >= LATGS_FROM);
        else
            return (w >= WRTGS_FROM);
    endfunction

    assign last_req = (word_cnt == LAST_WORD) && (plane_cnt == LAST_PLANE);

    always_ff @(posedge clk_33 or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable && !config_busy) state_nx = SHIFT;
            SHIFT: begin
                if (config_busy)   state_nx = IDLE;
                else if (last_req) state_nx = BLANK;
            end
            BLANK: begin
                if (config_busy)                  state_nx = IDLE;
                else if (blank_cnt == LAST_BLANK) state_nx = enable ? SHIFT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // An abort must stop requests in the very cycle config_busy is seen.
    always_comb begin
        driver_ready = (state == SHIFT) && !config_busy;
    end

    // Anything heading to IDLE (frame end or abort) restarts the next frame at plane 0, word 0.
    always_ff @(posedge clk_33 or posedge rst) begin
        if (rst) begin
            word_cnt  <= '0;
            plane_cnt <= '0;
            blank_cnt <= '0;
        end else if (state_nx == IDLE) begin
            word_cnt  <= '0;
            plane_cnt <= '0;
            blank_cnt <= '0;
        end else begin
            if (driver_ready) begin
                if (word_cnt == LAST_WORD) begin
                    word_cnt  <= '0;
                    plane_cnt <= (plane_cnt == LAST_PLANE) ? 4'd0 : plane_cnt + 4'd1;
                end else begin
                    word_cnt <= word_cnt + WORD_W'(1);
                end
            end
            blank_cnt <= (state == BLANK) ? blank_cnt + BLANK_W'(1) : '0;
        end
    end

    // Stage p0: request accepted last cycle; its tag rides along while the source returns data.
    always_ff @(posedge clk_33 or posedge rst) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            word_p0  <= '0;
            plane_p0 <= '0;
        end else begin
            vld_p0   <= driver_ready;
            word_p0  <= word_cnt;
            plane_p0 <= plane_cnt;
        end
    end

    // Stage p1: word captured onto the pins; config_busy drops anything still in flight.
    always_ff @(posedge clk_33 or posedge rst) begin
        if (rst) begin
            sclk_en    <= 1'b0;
            lat        <= 1'b0;
            plane_idx  <= '0;
            sin        <= '0;
            word_p1    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (config_busy) begin
                sclk_en   <= 1'b0;
                lat       <= 1'b0;
                plane_idx <= '0;
            end else begin
                sclk_en <= vld_p0;
                lat     <= vld_p0 && lat_for(word_p0, plane_p0);
                if (vld_p0) begin
                    sin       <= data;
                    plane_idx <= plane_p0;
                    word_p1   <= word_p0;
                end
            end
            frame_done <= !config_busy && sclk_en &&
                          (plane_idx == LAST_PLANE) && (word_p1 == LAST_WORD);
        end
    end

endmodule
